// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it as 32-bit little-endian words into instruction memory. The CPU is
// held in reset until a load completes with a matching checksum.
module imem_loader #(
    parameter int ADDR_WIDTH = 10,
    parameter int MAX_WORDS  = 1024
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  In_Valid,
    input  logic [7:0]            In_Data,
    output logic                  In_Ready,
    output logic                  Wr_En,
    output logic [ADDR_WIDTH-1:0] Wr_Addr,
    output logic [31:0]           Wr_Data,
    output logic                  Cpu_Reset,
    output logic                  Done,
    output logic                  Error
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR0 = 3'd1,
        ST_HDR1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // Widened by one bit so a 16-bit header length can be compared without overflow.
    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    // Running checksum update: plain XOR over data bytes.
    function automatic logic [7:0] csum_next(input logic [7:0] csum, input logic [7:0] b);
        return csum ^ b;
    endfunction

    state_t                state_r;
    logic                  in_ready_r;
    logic                  wr_en_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [31:0]           wr_data_r;
    logic                  cpu_reset_r;
    logic                  done_r;
    logic                  error_r;
    logic [15:0]           len_r;
    logic [15:0]           word_cnt_r;
    logic [1:0]            byte_cnt_r;
    logic [23:0]           word_r;      // first three bytes of the word in progress
    logic [7:0]            csum_r;

    logic                  accept_s;
    logic [15:0]           hdr_len_s;
    logic                  len_bad_s;
    logic [31:0]           word_s;
    logic                  last_word_s;

    assign accept_s    = In_Valid & in_ready_r;
    assign hdr_len_s   = {In_Data, len_r[7:0]};
    assign len_bad_s   = (hdr_len_s == 16'd0) || ({1'b0, hdr_len_s} > MAX_LEN);
    assign word_s      = {In_Data, word_r};
    assign last_word_s = (word_cnt_r == (len_r - 16'd1));

    assign In_Ready  = in_ready_r;
    assign Wr_En     = wr_en_r;
    assign Wr_Addr   = wr_addr_r;
    assign Wr_Data   = wr_data_r;
    assign Cpu_Reset = cpu_reset_r;
    assign Done      = done_r;
    assign Error     = error_r;

    // Load FSM: state, counters, checksum and all registered outputs.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b0;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 32'd0;
            cpu_reset_r <= 1'b1;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
            len_r       <= 16'd0;
            word_cnt_r  <= 16'd0;
            byte_cnt_r  <= 2'd0;
            word_r      <= 24'd0;
            csum_r      <= 8'd0;
        end else begin
            // The write strobe is a single-cycle pulse unless re-armed below.
            wr_en_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (Start) begin
                        state_r     <= ST_HDR0;
                        in_ready_r  <= 1'b1;
                        cpu_reset_r <= 1'b1;
                        done_r      <= 1'b0;
                        error_r     <= 1'b0;
                        len_r       <= 16'd0;
                        word_cnt_r  <= 16'd0;
                        byte_cnt_r  <= 2'd0;
                        word_r      <= 24'd0;
                        csum_r      <= 8'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_HDR0: begin
                    if (accept_s) begin
                        len_r[7:0] <= In_Data;
                        state_r    <= ST_HDR1;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_HDR1: begin
                    if (accept_s) begin
                        len_r[15:8] <= In_Data;
                        if (len_bad_s) begin
                            state_r     <= ST_ERR;
                            in_ready_r  <= 1'b0;
                            cpu_reset_r <= 1'b1;
                            error_r     <= 1'b1;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_DATA: begin
                    if (accept_s) begin
                        csum_r     <= csum_next(csum_r, In_Data);
                        word_r     <= {In_Data, word_r[23:8]};
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        if (byte_cnt_r == 2'd3) begin
                            wr_en_r    <= 1'b1;
                            wr_addr_r  <= word_cnt_r[ADDR_WIDTH-1:0];
                            wr_data_r  <= word_s;
                            word_cnt_r <= word_cnt_r + 16'd1;
                            if (last_word_s) begin
                                state_r <= ST_CSUM;
                            end else begin
                                state_r <= state_r;
                            end
                        end else begin
                            state_r <= state_r;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_CSUM: begin
                    if (accept_s) begin
                        in_ready_r <= 1'b0;
                        if (In_Data == csum_r) begin
                            state_r     <= ST_DONE;
                            done_r      <= 1'b1;
                            cpu_reset_r <= 1'b0;
                        end else begin
                            state_r     <= ST_ERR;
                            error_r     <= 1'b1;
                            cpu_reset_r <= 1'b1;
                        end
                    end else begin
                        state_r <= state_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    in_ready_r  <= 1'b0;
                    cpu_reset_r <= 1'b1;
                    done_r      <= 1'b0;
                    error_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte streams with hand-computed words and
// checksums, write capture on the falling edge, checks on the falling edge.
module tb_imem_loader;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        In_Valid;
    logic [7:0]  In_Data;
    logic        In_Ready;
    logic        Wr_En;
    logic [9:0]  Wr_Addr;
    logic [31:0] Wr_Data;
    logic        Cpu_Reset;
    logic        Done;
    logic        Error;

    int n_assert = 0;
    int n_fail   = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  seq[$];

    imem_loader #(.ADDR_WIDTH(10), .MAX_WORDS(1024)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .In_Valid  (In_Valid),
        .In_Data   (In_Data),
        .In_Ready  (In_Ready),
        .Wr_En     (Wr_En),
        .Wr_Addr   (Wr_Addr),
        .Wr_Data   (Wr_Data),
        .Cpu_Reset (Cpu_Reset),
        .Done      (Done),
        .Error     (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Capture every write strobe; a strobe held two cycles shows up twice.
    always @(negedge Clk) begin
        if (Wr_En === 1'b1) begin
            wa_q.push_back(Wr_Addr);
            wd_q.push_back(Wr_Data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wr_addr_at(input int i);
        if (i < wa_q.size()) return 32'(wa_q[i]);
        else return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] wr_data_at(input int i);
        if (i < wd_q.size()) return wd_q[i];
        else return 32'hFFFF_FFFF;
    endfunction

    // Offer one byte (starting at a falling edge) until it is accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        In_Valid = 1'b1;
        In_Data  = b;
        while (In_Ready !== 1'b1 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        chk("ready_timeout", 32'(In_Ready), 32'd1);
        @(posedge Clk);
        @(negedge Clk);
        In_Valid = 1'b0;
    endtask

    task automatic send_seq(input int gap);
        foreach (seq[i]) begin
            send_byte(seq[i]);
            repeat (gap) @(negedge Clk);
        end
    endtask

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
    endtask

    task automatic clear_writes();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        Reset    = 1'b0;
        Start    = 1'b1;
        In_Valid = 1'b1;
        In_Data  = 8'hA5;

        // Reset wins over simultaneous Start and In_Valid.
        repeat (3) @(negedge Clk);
        chk("rst_in_ready",  32'(In_Ready),  32'd0);
        chk("rst_wr_en",     32'(Wr_En),     32'd0);
        chk("rst_wr_addr",   32'(Wr_Addr),   32'd0);
        chk("rst_wr_data",   Wr_Data,        32'd0);
        chk("rst_cpu_reset", 32'(Cpu_Reset), 32'd1);
        chk("rst_done",      32'(Done),      32'd0);
        chk("rst_error",     32'(Error),     32'd0);

        // In_Valid in IDLE (In_Ready low) is ignored.
        Reset = 1'b1;
        Start = 1'b0;
        repeat (3) @(negedge Clk);
        In_Valid = 1'b0;
        chk("idle_in_ready", 32'(In_Ready), 32'd0);
        chk("idle_no_write", 32'(wa_q.size()), 32'd0);

        // Two-word load, good checksum 0x2A; a Start pulse mid-DATA is ignored.
        clear_writes();
        pulse_start();
        chk("hdr0_in_ready", 32'(In_Ready), 32'd1);
        seq = {8'h02, 8'h00, 8'h78, 8'h56};
        send_seq(0);
        pulse_start();
        seq = {8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
        send_seq(0);
        chk("ok_n_writes",   32'(wa_q.size()), 32'd2);
        chk("ok_addr0",      wr_addr_at(0), 32'd0);
        chk("ok_data0",      wr_data_at(0), 32'h1234_5678);
        chk("ok_addr1",      wr_addr_at(1), 32'd1);
        chk("ok_data1",      wr_data_at(1), 32'hDEAD_BEEF);
        chk("ok_done",       32'(Done),      32'd1);
        chk("ok_error",      32'(Error),     32'd0);
        chk("ok_cpu_reset",  32'(Cpu_Reset), 32'd0);
        chk("ok_in_ready",   32'(In_Ready),  32'd0);

        // Start in DONE: back to header state, CPU held again.
        clear_writes();
        pulse_start();
        chk("restart_done",      32'(Done),      32'd0);
        chk("restart_cpu_reset", 32'(Cpu_Reset), 32'd1);
        chk("restart_in_ready",  32'(In_Ready),  32'd1);

        // Same data, wrong checksum: both writes still happen, then error.
        seq = {8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
        send_seq(0);
        chk("bad_n_writes",  32'(wa_q.size()), 32'd2);
        chk("bad_data0",     wr_data_at(0), 32'h1234_5678);
        chk("bad_data1",     wr_data_at(1), 32'hDEAD_BEEF);
        chk("bad_error",     32'(Error),     32'd1);
        chk("bad_done",      32'(Done),      32'd0);
        chk("bad_cpu_reset", 32'(Cpu_Reset), 32'd1);

        // Zero-length header from ERR.
        clear_writes();
        pulse_start();
        chk("err_restart_error", 32'(Error), 32'd0);
        seq = {8'h00, 8'h00};
        send_seq(0);
        @(negedge Clk);
        chk("len0_error",    32'(Error),    32'd1);
        chk("len0_in_ready", 32'(In_Ready), 32'd0);
        chk("len0_no_write", 32'(wa_q.size()), 32'd0);

        // Length 1025: one over the limit.
        pulse_start();
        seq = {8'h01, 8'h04};
        send_seq(0);
        @(negedge Clk);
        chk("len1025_error",    32'(Error), 32'd1);
        chk("len1025_done",     32'(Done),  32'd0);
        chk("len1025_no_write", 32'(wa_q.size()), 32'd0);

        // Length 1024: exactly the limit, accepted into DATA.
        pulse_start();
        seq = {8'h00, 8'h04};
        send_seq(0);
        chk("len1024_error",    32'(Error),    32'd0);
        chk("len1024_in_ready", 32'(In_Ready), 32'd1);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        chk("len1024_rst_ready", 32'(In_Ready), 32'd0);

        // N=1 with In_Valid gapped every other cycle; checksum 0x44.
        clear_writes();
        pulse_start();
        seq = {8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        send_seq(1);
        chk("gap_n_writes", 32'(wa_q.size()), 32'd1);
        chk("gap_addr0",    wr_addr_at(0), 32'd0);
        chk("gap_data0",    wr_data_at(0), 32'h4433_2211);
        chk("gap_done",     32'(Done),  32'd1);
        chk("gap_error",    32'(Error), 32'd0);

        // Reset mid-word discards the partial word; a fresh load lands at 0.
        clear_writes();
        pulse_start();
        seq = {8'h01, 8'h00, 8'hAA, 8'hBB};
        send_seq(0);
        Reset = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        chk("abort_no_write",  32'(wa_q.size()), 32'd0);
        chk("abort_cpu_reset", 32'(Cpu_Reset),  32'd1);
        chk("abort_in_ready",  32'(In_Ready),   32'd0);
        pulse_start();
        seq = {8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04};
        send_seq(0);
        chk("fresh_n_writes",  32'(wa_q.size()), 32'd1);
        chk("fresh_addr0",     wr_addr_at(0), 32'd0);
        chk("fresh_data0",     wr_data_at(0), 32'h0403_0201);
        chk("fresh_done",      32'(Done),      32'd1);
        chk("fresh_cpu_reset", 32'(Cpu_Reset), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
